pixel_compositor: RTL and testbench

Registered, parametrised successor to the combinational pixel generator. It composites the header text band, side walls, two paddles, a scalable round ball and the background image into 12-bit RGB through a 2-stage pipeline. Sync signals are delayed through the same pipeline so they stay aligned with the pixels. Object positions are frame-latched, which removes tearing, and a per-paddle hit-flash effect is driven by the game logic. The block sits between the VGA timing/game-state modules and the DAC pins.

---
 rtl/pixel_compositor.sv | 160 ++++++++++++++++
 tb/tb_pixel_compositor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_compositor.sv
// pixel_compositor: two-stage registered compositor of header, walls, paddles, ball and background
module pixel_compositor #(
    parameter int          TOP_MARGIN      = 25,
    parameter int          WALL_W          = 32,
    parameter int          PADDLE_W        = 8,
    parameter int          PADDLE_H        = 72,
    parameter int          BALL_SCALE      = 1,
    parameter int          FLASH_FRAMES    = 8,
    parameter logic [11:0] WALL_COLOR      = 12'h89C,
    parameter logic [11:0] PADDLE_COLOR    = 12'h24F,
    parameter logic [11:0] FLASH_COLOR     = 12'hFFF,
    parameter logic [11:0] BALL_COLOR      = 12'hACE,
    parameter logic [11:0] HEADER_BG_COLOR = 12'h135
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_tick,
    input  logic        frame_tick,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    input  logic [9:0]  paddle1_y,
    input  logic [9:0]  paddle2_y,
    input  logic        hit1,
    input  logic        hit2,
    input  logic [11:0] bg_pixel,
    input  logic        text_on,
    input  logic [11:0] text_rgb,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out
);
    localparam int FW      = $clog2(FLASH_FRAMES + 1);
    localparam int SH      = (BALL_SCALE == 4) ? 2 : (BALL_SCALE == 2) ? 1 : 0;
    localparam int BALL_SZ = 8 * BALL_SCALE;
    // 8x8 disc; byte r is ROM row r, bit c is column c
    localparam logic [63:0] DISC = {8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C};

    logic [9:0]    sh_bx, sh_by, sh_p1, sh_p2;
    logic [FW-1:0] f1, f2;
    logic [10:0]   xe, ye, bxe, bye, p1t, p2t, dx, dy;
    logic [2:0]    row, col;
    logic          below_hdr, lpad_x, rpad_x, ball_box;
    logic          header_c, lwall_c, rwall_c, pad1_c, pad2_c, ball_c;
    logic          s1_header, s1_lwall, s1_rwall, s1_pad1, s1_pad2, s1_ball;
    logic          s1_text_on, s1_video_on, s1_hsync, s1_vsync;
    logic [11:0]   s1_text_rgb, s1_bg;
    logic [11:0]   pad1_rgb, pad2_rgb, rgb_c;

    // frame-latched object positions so a frame never shows a mix of old and new positions
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_bx <= '0;
            sh_by <= '0;
            sh_p1 <= '0;
            sh_p2 <= '0;
        end else if (frame_tick) begin
            sh_bx <= ball_x;
            sh_by <= ball_y;
            sh_p1 <= paddle1_y;
            sh_p2 <= paddle2_y;
        end
    end

    // hit flash counters: a hit reloads and beats a coincident frame decrement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f1 <= '0;
            f2 <= '0;
        end else begin
            f1 <= hit1 ? FW'(FLASH_FRAMES) : (frame_tick && f1 != '0) ? f1 - FW'(1) : f1;
            f2 <= hit2 ? FW'(FLASH_FRAMES) : (frame_tick && f2 != '0) ? f2 - FW'(1) : f2;
        end
    end

    // region tests at 11 bits so sums past the screen edge never wrap
    always_comb begin
        xe        = {1'b0, x};
        ye        = {1'b0, y};
        bxe       = {1'b0, sh_bx};
        bye       = {1'b0, sh_by};
        p1t       = {1'b0, sh_p1} + 11'(TOP_MARGIN);
        p2t       = {1'b0, sh_p2} + 11'(TOP_MARGIN);
        dx        = xe - bxe;
        dy        = ye - bye;
        row       = 3'(dy >> SH);
        col       = 3'(dx >> SH);
        below_hdr = ye >= 11'(TOP_MARGIN);
        lpad_x    = xe >= 11'(WALL_W) && xe <= 11'(WALL_W + PADDLE_W);
        rpad_x    = xe >= 11'(640 - WALL_W - PADDLE_W) && xe <= 11'(640 - WALL_W);
        ball_box  = xe >= bxe && xe <= bxe + 11'(BALL_SZ - 1) &&
                    ye >= bye && ye <= bye + 11'(BALL_SZ - 1);
        header_c  = !below_hdr;
        lwall_c   = below_hdr && xe < 11'(WALL_W);
        rwall_c   = below_hdr && xe > 11'(640 - WALL_W);
        pad1_c    = below_hdr && lpad_x && ye >= p1t && ye <= p1t + 11'(PADDLE_H);
        pad2_c    = below_hdr && rpad_x && ye >= p2t && ye <= p2t + 11'(PADDLE_H);
        ball_c    = ball_box && DISC[{row, col}];
    end

    // stage 1: capture region flags and the per-pixel side data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_header   <= 1'b0;
            s1_lwall    <= 1'b0;
            s1_rwall    <= 1'b0;
            s1_pad1     <= 1'b0;
            s1_pad2     <= 1'b0;
            s1_ball     <= 1'b0;
            s1_text_on  <= 1'b0;
            s1_text_rgb <= '0;
            s1_bg       <= '0;
            s1_video_on <= 1'b0;
            s1_hsync    <= 1'b1;
            s1_vsync    <= 1'b1;
        end else if (pixel_tick) begin
            s1_header   <= header_c;
            s1_lwall    <= lwall_c;
            s1_rwall    <= rwall_c;
            s1_pad1     <= pad1_c;
            s1_pad2     <= pad2_c;
            s1_ball     <= ball_c;
            s1_text_on  <= text_on;
            s1_text_rgb <= text_rgb;
            s1_bg       <= bg_pixel;
            s1_video_on <= video_on;
            s1_hsync    <= hsync_in;
            s1_vsync    <= vsync_in;
        end
    end

    // layer priority: blanking, header, walls, paddles, ball, background
    always_comb begin
        pad1_rgb = (f1 != '0 && f1[0]) ? FLASH_COLOR : PADDLE_COLOR;
        pad2_rgb = (f2 != '0 && f2[0]) ? FLASH_COLOR : PADDLE_COLOR;
        rgb_c    = !s1_video_on             ? 12'h000 :
                   s1_header                ? (s1_text_on ? s1_text_rgb : HEADER_BG_COLOR) :
                   (s1_lwall || s1_rwall)   ? WALL_COLOR :
                   s1_pad1                  ? pad1_rgb :
                   s1_pad2                  ? pad2_rgb :
                   s1_ball                  ? BALL_COLOR : s1_bg;
    end

    // stage 2: colour and syncs leave together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb       <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else if (pixel_tick) begin
            rgb       <= rgb_c;
            hsync_out <= s1_hsync;
            vsync_out <= s1_vsync;
        end
    end
endmodule

// File: tb/tb_pixel_compositor.sv
// tb_pixel_compositor: directed and randomized checks of pixel_compositor at ball scales 1 and 2
module tb_pixel_compositor;
    logic        clk = 0, reset = 1, pixel_tick = 0, frame_tick = 0;
    logic [9:0]  x = 0, y = 0, ball_x = 0, ball_y = 0, paddle1_y = 0, paddle2_y = 0;
    logic        video_on = 0, hsync_in = 1, vsync_in = 1, hit1 = 0, hit2 = 0, text_on = 0;
    logic [11:0] bg_pixel = 0, text_rgb = 0;
    logic [11:0] rgb1, rgb2;
    logic        hs1, vs1, hs2, vs2;
    int          total = 0, bad = 0;
    int          m_bx = 0, m_by = 0, m_p1 = 0, m_p2 = 0, m_f1 = 0, m_f2 = 0;
    localparam logic [7:0] DISC [8] = '{8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C};

    pixel_compositor dut1 (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .frame_tick(frame_tick),
        .x(x), .y(y), .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .ball_x(ball_x), .ball_y(ball_y), .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
        .hit1(hit1), .hit2(hit2), .bg_pixel(bg_pixel), .text_on(text_on), .text_rgb(text_rgb),
        .rgb(rgb1), .hsync_out(hs1), .vsync_out(vs1));

    pixel_compositor #(.BALL_SCALE(2)) dut2 (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .frame_tick(frame_tick),
        .x(x), .y(y), .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .ball_x(ball_x), .ball_y(ball_y), .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
        .hit1(hit1), .hit2(hit2), .bg_pixel(bg_pixel), .text_on(text_on), .text_rgb(text_rgb),
        .rgb(rgb2), .hsync_out(hs2), .vsync_out(vs2));

    always #5 clk = ~clk;

    // expected colour of one pixel from the screen layout rules and the model's latched state
    function automatic logic [11:0] ref_rgb(int px, int py, bit vid, bit ton,
                                            logic [11:0] trgb, logic [11:0] bg, int sc);
        if (!vid) return 12'h000;
        if (py < 25) return ton ? trgb : 12'h135;
        if (px < 32 || px > 608) return 12'h89C;
        if (px >= 32 && px <= 40 && py >= m_p1 + 25 && py <= m_p1 + 97)
            return (m_f1 % 2 == 1) ? 12'hFFF : 12'h24F;
        if (px >= 600 && px <= 608 && py >= m_p2 + 25 && py <= m_p2 + 97)
            return (m_f2 % 2 == 1) ? 12'hFFF : 12'h24F;
        if (px >= m_bx && px < m_bx + 8 * sc && py >= m_by && py < m_by + 8 * sc &&
            DISC[(py - m_by) / sc][(px - m_bx) / sc])
            return 12'hACE;
        return bg;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic latch(int bx, int by, int p1, int p2);
        ball_x = 10'(bx); ball_y = 10'(by); paddle1_y = 10'(p1); paddle2_y = 10'(p2);
        pixel_tick = 0; frame_tick = 1;
        step();
        frame_tick = 0;
        m_bx = bx; m_by = by; m_p1 = p1; m_p2 = p2;
        if (m_f1 > 0) m_f1--;
        if (m_f2 > 0) m_f2--;
    endtask

    task automatic show(int px, int py);
        x = 10'(px); y = 10'(py); video_on = 1; pixel_tick = 1;
        step();
        step();
    endtask

    task automatic test_reset();
        video_on = 1; pixel_tick = 1; hsync_in = 0; vsync_in = 0;
        repeat (3) step();
        total++;
        if (rgb1 !== 12'h000 || hs1 !== 1'b1 || vs1 !== 1'b1) begin
            bad++; $display("FAIL reset_state got rgb=%h hs=%b vs=%b exp 000 1 1", rgb1, hs1, vs1);
        end
        reset = 0; video_on = 0; hsync_in = 1; vsync_in = 1;
        step(); step();
        total++;
        if (rgb1 !== 12'h000 || hs1 !== 1'b1 || vs1 !== 1'b1) begin
            bad++; $display("FAIL idle_blank got rgb=%h hs=%b vs=%b exp 000 1 1", rgb1, hs1, vs1);
        end
        hsync_in = 0;
        step();
        hsync_in = 1;
        total++;
        if (hs1 !== 1'b1) begin bad++; $display("FAIL hsync_early got=%b exp=1", hs1); end
        step();
        total++;
        if (hs1 !== 1'b0) begin bad++; $display("FAIL hsync_lat2 got=%b exp=0", hs1); end
        step();
        total++;
        if (hs1 !== 1'b1) begin bad++; $display("FAIL hsync_release got=%b exp=1", hs1); end
    endtask

    task automatic test_ball_scale1();
        bg_pixel = 12'h0A5; text_on = 0;
        latch(100, 200, 400, 400);
        show(100, 200);
        total++; if (rgb1 !== 12'h0A5) begin bad++; $display("FAIL ball1_corner got=%h exp=0a5", rgb1); end
        show(103, 200);
        total++; if (rgb1 !== 12'hACE) begin bad++; $display("FAIL ball1_top got=%h exp=ace", rgb1); end
        show(108, 200);
        total++; if (rgb1 !== 12'h0A5) begin bad++; $display("FAIL ball1_right got=%h exp=0a5", rgb1); end
        show(107, 203);
        total++; if (rgb1 !== 12'hACE) begin bad++; $display("FAIL ball1_edge got=%h exp=ace", rgb1); end
    endtask

    task automatic test_ball_scale2();
        latch(300, 300, 400, 400);
        show(302, 300);
        total++; if (rgb2 !== 12'h0A5) begin bad++; $display("FAIL ball2_col1 got=%h exp=0a5", rgb2); end
        show(304, 300);
        total++; if (rgb2 !== 12'hACE) begin bad++; $display("FAIL ball2_col2 got=%h exp=ace", rgb2); end
        show(315, 306);
        total++; if (rgb2 !== 12'hACE) begin bad++; $display("FAIL ball2_far got=%h exp=ace", rgb2); end
        show(316, 306);
        total++; if (rgb2 !== 12'h0A5) begin bad++; $display("FAIL ball2_out got=%h exp=0a5", rgb2); end
    endtask

    task automatic test_paddle_latch();
        latch(500, 400, 0, 0);
        show(35, 30);
        total++; if (rgb1 !== 12'h24F) begin bad++; $display("FAIL pad_old got=%h exp=24f", rgb1); end
        paddle1_y = 10'd50;
        show(35, 30);
        total++; if (rgb1 !== 12'h24F) begin bad++; $display("FAIL pad_no_latch got=%h exp=24f", rgb1); end
        latch(500, 400, 50, 50);
        show(35, 30);
        total++; if (rgb1 !== 12'h0A5) begin bad++; $display("FAIL pad_moved got=%h exp=0a5", rgb1); end
        show(35, 75);
        total++; if (rgb1 !== 12'h24F) begin bad++; $display("FAIL pad_top got=%h exp=24f", rgb1); end
        show(35, 147);
        total++; if (rgb1 !== 12'h24F) begin bad++; $display("FAIL pad_bottom got=%h exp=24f", rgb1); end
        show(35, 148);
        total++; if (rgb1 !== 12'h0A5) begin bad++; $display("FAIL pad_below got=%h exp=0a5", rgb1); end
        show(605, 75);
        total++; if (rgb1 !== 12'h24F) begin bad++; $display("FAIL pad2 got=%h exp=24f", rgb1); end
        show(609, 75);
        total++; if (rgb1 !== 12'h89C) begin bad++; $display("FAIL rwall got=%h exp=89c", rgb1); end
        show(599, 75);
        total++; if (rgb1 !== 12'h0A5) begin bad++; $display("FAIL pad2_left got=%h exp=0a5", rgb1); end
    endtask

    task automatic test_flash();
        logic [11:0] e;
        hit1 = 1; frame_tick = 1; pixel_tick = 0;
        step();
        hit1 = 0; frame_tick = 0;
        m_f1 = 8;
        if (m_f2 > 0) m_f2--;
        for (int i = 0; i < 10; i++) begin
            show(35, 100);
            e = (m_f1 % 2 == 1) ? 12'hFFF : 12'h24F;
            total++;
            if (rgb1 !== e) begin bad++; $display("FAIL flash_%0d got=%h exp=%h", i, rgb1, e); end
            latch(500, 400, 50, 50);
        end
        hit2 = 1; pixel_tick = 0;
        step();
        hit2 = 0; m_f2 = 8;
        show(605, 100);
        total++; if (rgb1 !== 12'h24F) begin bad++; $display("FAIL flash2_load got=%h exp=24f", rgb1); end
        latch(500, 400, 50, 50);
        show(605, 100);
        total++; if (rgb1 !== 12'hFFF) begin bad++; $display("FAIL flash2_odd got=%h exp=fff", rgb1); end
    endtask

    task automatic test_header();
        latch(16, 96, 50, 50);
        text_on = 1; text_rgb = 12'hF00;
        show(200, 10);
        total++; if (rgb1 !== 12'hF00) begin bad++; $display("FAIL hdr_text got=%h exp=f00", rgb1); end
        text_on = 0;
        show(200, 10);
        total++; if (rgb1 !== 12'h135) begin bad++; $display("FAIL hdr_bg got=%h exp=135", rgb1); end
        show(20, 100);
        total++; if (rgb1 !== 12'h89C) begin bad++; $display("FAIL wall_over_ball got=%h exp=89c", rgb1); end
    endtask

    task automatic test_hold();
        pixel_tick = 0; x = 10'd300; y = 10'd5; video_on = 0; hsync_in = 0; vsync_in = 0;
        repeat (3) step();
        total++;
        if (rgb1 !== 12'h89C || hs1 !== 1'b1 || vs1 !== 1'b1) begin
            bad++; $display("FAIL hold got rgb=%h hs=%b vs=%b exp 89c 1 1", rgb1, hs1, vs1);
        end
        hsync_in = 1; vsync_in = 1;
    endtask

    task automatic test_async_reset();
        show(20, 100);
        #2 reset = 1;
        #1;
        total++;
        if (rgb1 !== 12'h000 || hs1 !== 1'b1) begin
            bad++; $display("FAIL async_reset got rgb=%h hs=%b exp 000 1", rgb1, hs1);
        end
        #1 reset = 0;
        m_bx = 0; m_by = 0; m_p1 = 0; m_p2 = 0; m_f1 = 0; m_f2 = 0;
        step();
        total++; if (rgb1 !== 12'h000) begin bad++; $display("FAIL post_reset_1 got=%h exp=000", rgb1); end
        step();
        total++; if (rgb1 !== 12'h89C) begin bad++; $display("FAIL post_reset_2 got=%h exp=89c", rgb1); end
    endtask

    task automatic test_random();
        logic [25:0] q[$];
        logic [25:0] e;
        int px, py, mode;
        for (int r = 0; r < 8; r++) begin
            latch($urandom_range(0, 620), $urandom_range(0, 470), $urandom_range(0, 400), $urandom_range(0, 400));
            q.delete();
            for (int c = 0; c < 150; c++) begin
                mode = $urandom_range(0, 2);
                if (mode == 0) begin
                    px = m_bx + $urandom_range(0, 24) - 4; py = m_by + $urandom_range(0, 24) - 4;
                end else if (mode == 1) begin
                    px = ($urandom_range(0, 1) != 0) ? 28 + $urandom_range(0, 16) : 596 + $urandom_range(0, 16);
                    py = (($urandom_range(0, 1) != 0) ? m_p1 : m_p2) + 21 + $urandom_range(0, 84);
                end else begin
                    px = $urandom_range(0, 639); py = $urandom_range(0, 479);
                end
                px = (px < 0) ? 0 : (px > 639) ? 639 : px;
                py = (py < 0) ? 0 : (py > 479) ? 479 : py;
                x = 10'(px); y = 10'(py);
                video_on = $urandom_range(0, 7) != 0; text_on = 1'($urandom);
                text_rgb = 12'($urandom); bg_pixel = 12'($urandom);
                hsync_in = 1'($urandom); vsync_in = 1'($urandom);
                pixel_tick = $urandom_range(0, 3) != 0;
                step();
                if (pixel_tick)
                    q.push_back({hsync_in, vsync_in,
                                 ref_rgb(px, py, video_on, text_on, text_rgb, bg_pixel, 1),
                                 ref_rgb(px, py, video_on, text_on, text_rgb, bg_pixel, 2)});
                if (q.size() >= 2) begin
                    e = q[q.size() - 2];
                    total++;
                    if ({hs1, vs1, rgb1, rgb2} !== e || hs2 !== e[25] || vs2 !== e[24]) begin
                        bad++;
                        $display("FAIL rand_r%0d_c%0d got hs=%b vs=%b rgb1=%h rgb2=%h exp hs=%b vs=%b rgb1=%h rgb2=%h",
                                 r, c, hs1, vs1, rgb1, rgb2, e[25], e[24], e[23:12], e[11:0]);
                    end
                end
            end
        end
        hsync_in = 1; vsync_in = 1; pixel_tick = 1;
    endtask

    initial begin
        test_reset();
        test_ball_scale1();
        test_ball_scale2();
        test_paddle_latch();
        test_flash();
        test_header();
        test_hold();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
